alu_result_stage: RTL and testbench

- Registered output stage directly downstream of the 32-bit bitwise (AND/OR) and adder slices of the ALU.
- Selects one slice result per operation and derives zero/carry flags.
- Holds results in a 2-entry skid buffer with valid/ready handshakes on both sides, so the ALU datapath runs at full throughput while the consumer can stall.

---
 rtl/alu_result_stage.sv | 168 ++++++++++++++++
 tb/tb_alu_result_stage.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_stage.sv
// alu_result_stage: registered output stage behind the AND/OR and adder slices of the ALU.
// It picks one slice result per operation and derives the zero and carry flags. Results are
// held in a 2-entry skid buffer (main + skid) with valid/ready handshakes on both sides.
//
// Ports:
//   clk, rst_n         rising-edge clock, synchronous active-low reset
//   in_valid/in_ready  upstream handshake; a transfer happens when both are high
//   sel                00 AND, 01 OR, 10 ADD/SUB, 11 SLT
//   and_res, or_res    bitwise slice outputs
//   sum_res            adder/subtractor sum
//   carry_in_flag      adder carry-out
//   set_bit            SLT compare result
//   out_valid/out_ready downstream handshake
//   result, zero, cout registered result and flags (main entry)
//
// Optional feature (macro ALU_STAGE_STATS_EN): adds xfer_cnt (output transfers) and
// stall_cnt (cycles with out_valid && !out_ready) statistics counters.
module alu_result_stage #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] and_res,
    input  logic [WIDTH-1:0] or_res,
    input  logic [WIDTH-1:0] sum_res,
    input  logic             carry_in_flag,
    input  logic             set_bit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             cout
`ifdef ALU_STAGE_STATS_EN
    ,
    output logic [CNT_W-1:0] xfer_cnt,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

    state_e state_q, state_d;

    logic [WIDTH-1:0] main_res_q, skid_res_q;
    logic             main_zero_q, skid_zero_q;
    logic             main_cout_q, skid_cout_q;

    logic [WIDTH-1:0] mux_res;
    logic             mux_zero;
    logic             mux_cout;

    logic acc, drn;
    logic load_main, load_skid, move_skid;

    // Entry validity is carried by the state: main valid in ONE/TWO, skid valid only in TWO.
    assign out_valid = (state_q != StEmpty);
    assign in_ready  = rst_n && (state_q != StTwo);

    assign acc = in_valid && in_ready;
    assign drn = out_valid && out_ready;

    assign result = main_res_q;
    assign zero   = main_zero_q;
    assign cout   = main_cout_q;

    always_comb begin
        mux_res  = '0;
        mux_cout = 1'b0;
        case (sel)
            2'b00:   mux_res = and_res;
            2'b01:   mux_res = or_res;
            2'b10: begin
                mux_res  = sum_res;
                mux_cout = carry_in_flag;
            end
            default: mux_res = {{(WIDTH-1){1'b0}}, set_bit};
        endcase
        mux_zero = (mux_res == '0);
    end

    always_comb begin
        state_d   = state_q;
        load_main = 1'b0;
        load_skid = 1'b0;
        move_skid = 1'b0;
        unique case (state_q)
            StEmpty: begin
                if (acc) begin
                    load_main = 1'b1;
                    state_d   = StOne;
                end
            end
            StOne: begin
                if (acc && !drn) begin
                    load_skid = 1'b1;
                    state_d   = StTwo;
                end else if (acc && drn) begin
                    load_main = 1'b1;
                end else if (drn) begin
                    state_d = StEmpty;
                end
            end
            StTwo: begin
                // in_ready is low here, so only a drain can happen.
                if (drn) begin
                    move_skid = 1'b1;
                    state_d   = StOne;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StEmpty;
            main_res_q  <= '0;
            main_zero_q <= 1'b0;
            main_cout_q <= 1'b0;
            skid_res_q  <= '0;
            skid_zero_q <= 1'b0;
            skid_cout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load_main) begin
                main_res_q  <= mux_res;
                main_zero_q <= mux_zero;
                main_cout_q <= mux_cout;
            end else if (move_skid) begin
                main_res_q  <= skid_res_q;
                main_zero_q <= skid_zero_q;
                main_cout_q <= skid_cout_q;
            end
            if (load_skid) begin
                skid_res_q  <= mux_res;
                skid_zero_q <= mux_zero;
                skid_cout_q <= mux_cout;
            end
        end
    end

`ifdef ALU_STAGE_STATS_EN
    logic [CNT_W-1:0] xfer_cnt_q, stall_cnt_q;

    // Both counters wrap naturally from all-ones to zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            xfer_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (drn) begin
                xfer_cnt_q <= xfer_cnt_q + 1'b1;
            end
            if (out_valid && !out_ready) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end
    end

    assign xfer_cnt  = xfer_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed testbench for alu_result_stage. Inputs change and outputs are sampled on the
// falling clock edge; the DUT samples on the rising edge.
module tb_alu_result_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  sel;
    logic [31:0] and_res;
    logic [31:0] or_res;
    logic [31:0] sum_res;
    logic        carry_in_flag;
    logic        set_bit;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        cout;

    int n_cmp;
    int n_err;

`ifdef ALU_STAGE_STATS_EN
    logic [15:0] xfer_cnt;
    logic [15:0] stall_cnt;

    alu_result_stage #(.WIDTH(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .sel(sel),
        .and_res(and_res), .or_res(or_res), .sum_res(sum_res), .carry_in_flag(carry_in_flag),
        .set_bit(set_bit), .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .zero(zero), .cout(cout), .xfer_cnt(xfer_cnt), .stall_cnt(stall_cnt)
    );
`else
    alu_result_stage #(.WIDTH(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .sel(sel),
        .and_res(and_res), .or_res(or_res), .sum_res(sum_res), .carry_in_flag(carry_in_flag),
        .set_bit(set_bit), .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .zero(zero), .cout(cout)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one entry on the input side (in_valid raised).
    task automatic drive(input logic [1:0] s, input logic [31:0] a, input logic [31:0] o,
                         input logic [31:0] sm, input logic c, input logic b);
        in_valid      = 1'b1;
        sel           = s;
        and_res       = a;
        or_res        = o;
        sum_res       = sm;
        carry_in_flag = c;
        set_bit       = b;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        sel = 2'b00;
        and_res = '0;
        or_res = '0;
        sum_res = '0;
        carry_in_flag = 1'b0;
        set_bit = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check_eq("rst_in_ready", {31'b0, in_ready}, 32'd0);
        check_eq("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check_eq("rst_result", result, 32'd0);
        check_eq("rst_flags", {30'b0, zero, cout}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

        // OR select, single cycle latency
        out_ready = 1'b1;
        drive(2'b01, 32'hFFFF_0000, 32'h0000_F0F0, 32'h1234_5678, 1'b1, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("or_valid", {31'b0, out_valid}, 32'd1);
        check_eq("or_result", result, 32'h0000_F0F0);
        check_eq("or_flags", {30'b0, zero, cout}, 32'd0);
        @(negedge clk);
        check_eq("or_drained", {31'b0, out_valid}, 32'd0);

        // Flag cases, back to back
        drive(2'b10, 32'h1, 32'h2, 32'h0000_0000, 1'b1, 1'b0);
        @(negedge clk);
        check_eq("add_result", result, 32'd0);
        check_eq("add_flags", {30'b0, zero, cout}, 32'b11);
        drive(2'b00, 32'h0, 32'hFFFF, 32'h5, 1'b1, 1'b0);
        @(negedge clk);
        check_eq("and_result", result, 32'd0);
        check_eq("and_flags", {30'b0, zero, cout}, 32'b10);
        drive(2'b11, 32'hFF, 32'hFF, 32'hFFFF_FFFF, 1'b1, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("slt_result", result, 32'h0000_0001);
        check_eq("slt_flags", {30'b0, zero, cout}, 32'd0);
        @(negedge clk);
        check_eq("slt_drained", {31'b0, out_valid}, 32'd0);

        // Full-throughput streaming with out_ready high
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                check_eq("stream_result", result, 32'h100 + i - 1);
                check_eq("stream_in_ready", {31'b0, in_ready}, 32'd1);
            end
            drive(2'b01, 32'h0, 32'h100 + i, 32'h0, 1'b0, 1'b0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check_eq("stream_last", result, 32'h104);
        @(negedge clk);

        // Stall: fill both entries, C is held off, then drain in order
        out_ready = 1'b0;
        drive(2'b10, 32'h0, 32'h0, 32'hAAAA_0001, 1'b1, 1'b0);
        @(negedge clk);
        check_eq("stall_a_in_ready", {31'b0, in_ready}, 32'd1);
        drive(2'b10, 32'h0, 32'h0, 32'hBBBB_0002, 1'b0, 1'b0);
        @(negedge clk);
        check_eq("full_in_ready", {31'b0, in_ready}, 32'd0);
        check_eq("full_hold_a", result, 32'hAAAA_0001);
        check_eq("full_hold_a_cout", {31'b0, cout}, 32'd1);
        drive(2'b01, 32'h0, 32'hCCCC_0003, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        check_eq("full_c_held_off", {31'b0, in_ready}, 32'd0);
        check_eq("full_still_a", result, 32'hAAAA_0001);
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("drain_b", result, 32'hBBBB_0002);
        check_eq("drain_b_cout", {31'b0, cout}, 32'd0);
        check_eq("drain_in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("drain_c", result, 32'hCCCC_0003);
        check_eq("drain_c_valid", {31'b0, out_valid}, 32'd1);
        @(negedge clk);
        check_eq("drain_empty", {31'b0, out_valid}, 32'd0);

        // Reset while full
        out_ready = 1'b0;
        drive(2'b10, 32'h0, 32'h0, 32'h0000_1234, 1'b1, 1'b0);
        @(negedge clk);
        drive(2'b01, 32'h0, 32'h0000_5678, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("pre_rst_full", {31'b0, in_ready}, 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        check_eq("midrst_result", result, 32'd0);
        check_eq("midrst_flags", {30'b0, zero, cout}, 32'd0);
        check_eq("midrst_in_ready", {31'b0, in_ready}, 32'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("postrst_in_ready", {31'b0, in_ready}, 32'd1);
        check_eq("postrst_empty", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        check_eq("postrst_no_ghost", {31'b0, out_valid}, 32'd0);
        drive(2'b00, 32'h0000_00F1, 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("postrst_new_entry", result, 32'h0000_00F1);
        @(negedge clk);

`ifdef ALU_STAGE_STATS_EN
        // Statistics: clean reset, 3 transfers with 2 stall cycles, then wrap
        out_ready = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_eq("cnt_rst_xfer", {16'b0, xfer_cnt}, 32'd0);
        check_eq("cnt_rst_stall", {16'b0, stall_cnt}, 32'd0);
        drive(2'b01, 32'h0, 32'h1, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        out_ready = 1'b1;
        drive(2'b01, 32'h0, 32'h2, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        drive(2'b01, 32'h0, 32'h3, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("cnt_xfer_3", {16'b0, xfer_cnt}, 32'd3);
        check_eq("cnt_stall_2", {16'b0, stall_cnt}, 32'd2);
        drive(2'b01, 32'h0, 32'h4, 32'h0, 1'b0, 1'b0);
        repeat (65532) @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("cnt_xfer_ffff", {16'b0, xfer_cnt}, 32'h0000_FFFF);
        check_eq("cnt_stall_kept", {16'b0, stall_cnt}, 32'd2);
        drive(2'b01, 32'h0, 32'h5, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("cnt_xfer_wrap", {16'b0, xfer_cnt}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
